seed_writer: RTL and testbench

- Produces the 16-bit RNG seed and writes it into data memory at the seed word (16'h07FE). The LFSR random generator later loads this word when it leaves reset.
- Seed entropy comes from a free-running cycle counter, sampled when a debounced user trigger (button) is seen.
- Sits between the board trigger input and the shared memory write port.

---
 rtl/seed_writer_pkg.sv | 23 ++
 rtl/seed_writer_if.sv | 10 +
 rtl/seed_writer_trigger_debounce.sv | 38 +++
 rtl/seed_writer.sv | 123 ++++++++++++
 tb/tb_seed_writer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/seed_writer_pkg.sv
// Shared definitions for the RNG seed writer: FSM encoding, seed word address and the
// XNOR-LFSR lockup value with its substitute.
package seed_writer_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWrite = 3'd1,
        StRead  = 3'd2,
        StCheck = 3'd3,
        StDone  = 3'd4
    } state_e;

    // Must match the seed address the random generator loads from.
    localparam logic [15:0] SeedAddrDefault = 16'h07FE;

    localparam logic [15:0] LfsrLockup      = 16'hFFFF;
    localparam logic [15:0] LfsrLockupSubst = 16'hFFFE;

    function automatic logic [15:0] guard_seed(logic [15:0] raw);
        return (raw == LfsrLockup) ? LfsrLockupSubst : raw;
    endfunction

endpackage

// File: rtl/seed_writer_if.sv
// Single-port data memory write/read bus used by the seed writer.
interface seed_writer_if;
    logic [15:0] address;
    logic        wr_en;
    logic [15:0] data_in;
    logic [15:0] mem_data_out;

    modport master (output address, output wr_en, output data_in, input mem_data_out);
    modport slave  (input address, input wr_en, input data_in, output mem_data_out);
endinterface

// File: rtl/seed_writer_trigger_debounce.sv
// Two-flop synchronizer plus saturating debounce counter; emits one pulse per qualified
// press, re-armed only after the synchronized level returns low.
module seed_writer_trigger_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic nreset,
    input  logic trigger_i,
    output logic event_o
);
    localparam logic [7:0] Target = 8'(DEBOUNCE_CYCLES);

    logic       sync1_q, sync2_q;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            sync1_q <= trigger_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = 8'd0;
        if (sync2_q) begin
            cnt_d = (cnt_q == Target) ? Target : cnt_q + 8'd1;
        end
    end

    // Fires in the cycle whose closing edge brings the count up to the target.
    assign event_o = sync2_q && (cnt_q == Target - 8'd1);

endmodule

// File: rtl/seed_writer.sv
// Samples a free-running counter on a debounced trigger and writes it as the RNG seed.
// SEED_WRITER_READBACK_EN adds read-back verification with bounded rewrites.
module seed_writer
    import seed_writer_pkg::*;
#(
    parameter logic [15:0] SEED_ADDR       = SeedAddrDefault,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MAX_RETRY       = 3
) (
    input  logic          clock,
    input  logic          nreset,
    input  logic          trigger_i,
    seed_writer_if.master mem,
    output logic [15:0]   seed_out_o,
    output logic          seed_valid_o,
    output logic          busy_o,
    output logic          seed_error_o
);
    logic [15:0] entropy_q;
    logic [15:0] data_in_q, data_in_d;
    logic [15:0] seed_out_q, seed_out_d;
    state_e      state_q, state_d;
    logic        trig_event;

    seed_writer_trigger_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock    (clock),
        .nreset   (nreset),
        .trigger_i(trigger_i),
        .event_o  (trig_event)
    );

`ifdef SEED_WRITER_READBACK_EN
    localparam logic [7:0] MaxRetry = 8'(MAX_RETRY);
    logic [7:0] retry_q, retry_d;
    logic       error_q, error_d;
`else
    localparam int unsigned unused_max_retry = MAX_RETRY;
    logic [15:0] unused_rdata;
    assign unused_rdata = mem.mem_data_out;
`endif

    always_ff @(posedge clock) begin
        if (!nreset) begin
            entropy_q  <= 16'h0001;
            state_q    <= StIdle;
            data_in_q  <= 16'h0000;
            seed_out_q <= 16'h0000;
`ifdef SEED_WRITER_READBACK_EN
            retry_q    <= 8'd0;
            error_q    <= 1'b0;
`endif
        end else begin
            entropy_q  <= entropy_q + 16'd1;
            state_q    <= state_d;
            data_in_q  <= data_in_d;
            seed_out_q <= seed_out_d;
`ifdef SEED_WRITER_READBACK_EN
            retry_q    <= retry_d;
            error_q    <= error_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        data_in_d  = data_in_q;
        seed_out_d = seed_out_q;
`ifdef SEED_WRITER_READBACK_EN
        retry_d    = retry_q;
        error_d    = error_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (trig_event) begin
                    data_in_d = guard_seed(entropy_q);
                    state_d   = StWrite;
`ifdef SEED_WRITER_READBACK_EN
                    retry_d   = 8'd0;
`endif
                end
            end
            StWrite: begin
                seed_out_d = data_in_q;
`ifdef SEED_WRITER_READBACK_EN
                state_d    = StRead;
`else
                state_d    = StDone;
`endif
            end
`ifdef SEED_WRITER_READBACK_EN
            StRead:  state_d = StCheck;
            StCheck: begin
                if (mem.mem_data_out == data_in_q) begin
                    state_d = StDone;
                end else if (retry_q < MaxRetry) begin
                    retry_d = retry_q + 8'd1;
                    state_d = StWrite;
                end else begin
                    error_d = 1'b1;
                    state_d = StDone;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    assign mem.address  = SEED_ADDR;
    assign mem.wr_en    = (state_q == StWrite);
    assign mem.data_in  = data_in_q;
    assign seed_out_o   = seed_out_q;
    assign busy_o       = !((state_q == StIdle) || (state_q == StDone));
`ifdef SEED_WRITER_READBACK_EN
    assign seed_valid_o = (state_q == StDone) && !error_q;
    assign seed_error_o = error_q;
`else
    assign seed_valid_o = (state_q == StDone);
    assign seed_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_seed_writer.sv
// Directed-random bench for seed_writer: seeds are predicted from elapsed cycles since reset,
// and a single-word memory model observes every write.
module tb_seed_writer;
    localparam int unsigned DEB     = 4;
    localparam int unsigned RETRIES = 3;

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic        trigger = 1'b0;
    logic [15:0] seed_out;
    logic        seed_valid, busy, seed_error;

    seed_writer_if bus ();

    seed_writer #(
        .SEED_ADDR      (16'h07FE),
        .DEBOUNCE_CYCLES(DEB),
        .MAX_RETRY      (RETRIES)
    ) dut (
        .clock       (clock),
        .nreset      (nreset),
        .trigger_i   (trigger),
        .mem         (bus),
        .seed_out_o  (seed_out),
        .seed_valid_o(seed_valid),
        .busy_o      (busy),
        .seed_error_o(seed_error)
    );

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    longint      rel_cyc = 0;
    bit          corrupt = 1'b0;
    bit          prev_wr = 1'b0;
    logic [15:0] mem_word = 16'h0000;

    longint      wr_cyc_q[$];
    logic [15:0] wr_dat_q[$];
    logic        wr_val_q[$];
    logic        wr_busy_q[$];

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Memory: registered read of the seed word, optionally corrupted on the way out.
    always @(posedge clock) begin
        if (bus.wr_en === 1'b1 && bus.address === 16'h07FE) mem_word <= bus.data_in;
        bus.mem_data_out <= corrupt ? (mem_word ^ 16'h0100) : mem_word;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (bus.wr_en === 1'b1) begin
            chk("wr_addr", 32'(bus.address), 32'h07FE);
            chk("wr_not_back_to_back", 32'(prev_wr), 32'd0);
            wr_cyc_q.push_back(cyc);
            wr_dat_q.push_back(bus.data_in);
            wr_val_q.push_back(seed_valid);
            wr_busy_q.push_back(busy);
        end
        prev_wr = (bus.wr_en === 1'b1);
    end

    // Counter reads 1 in the cycle of the last reset edge and advances once per cycle.
    function automatic logic [15:0] model_seed(input longint k);
        logic [15:0] v;
        v = 16'(1 + k - rel_cyc);
        return (v == 16'hFFFF) ? 16'hFFFE : v;
    endfunction

    task automatic do_reset(input int n);
        nreset = 1'b0;
        repeat (n) @(posedge clock);
        #1;
        rel_cyc = cyc;
        nreset  = 1'b1;
    endtask

    // Holds trigger high for hi cycles starting now; optional one-cycle glitch lands in WRITE.
    task automatic qual(input int hi, input bit glitch, input int exp_writes,
                        input bit exp_valid, input bit exp_err);
        longint      c0;
        int          n0;
        int          got;
        logic [15:0] exp_seed;
        c0       = cyc;
        n0       = wr_cyc_q.size();
        exp_seed = model_seed(c0 + 1 + longint'(DEB));
        for (int i = 0; i < hi + 30; i++) begin
            trigger = (i < hi) || (glitch && i == 6);
            @(posedge clock);
            #1;
        end
        got = wr_cyc_q.size() - n0;
        chk("write_count", 32'(got), 32'(exp_writes));
        for (int j = 0; j < got && j < exp_writes; j++)
            chk("write_data", 32'(wr_dat_q[n0+j]), 32'(exp_seed));
        if (got > 0) begin
            chk("write_latency", 32'(wr_cyc_q[n0] - c0), 32'(2 + DEB));
            chk("valid_in_write", 32'(wr_val_q[n0]), 32'd0);
            chk("busy_in_write", 32'(wr_busy_q[n0]), 32'd1);
        end
        if (exp_writes > 0) begin
            chk("seed_out", 32'(seed_out), 32'(exp_seed));
            chk("seed_valid", 32'(seed_valid), 32'(exp_valid));
            chk("busy_done", 32'(busy), 32'd0);
            chk("seed_error", 32'(seed_error), 32'(exp_err));
        end
    endtask

    initial begin
        longint d;

        do_reset(3);
        chk("rst_address", 32'(bus.address), 32'h07FE);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_data_in", 32'(bus.data_in), 32'd0);
        chk("rst_seed_out", 32'(seed_out), 32'd0);
        chk("rst_seed_valid", 32'(seed_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_seed_error", 32'(seed_error), 32'd0);

        qual(3, 1'b0, 0, 1'b0, 1'b0);
        qual(10, 1'b0, 1, 1'b1, 1'b0);

        for (int t = 0; t < 5; t++) begin
            repeat ($urandom_range(0, 40)) @(posedge clock);
            #1;
            qual(int'($urandom_range(DEB, 12)), 1'b0, 1, 1'b1, 1'b0);
        end

        qual(DEB, 1'b1, 1, 1'b1, 1'b0);

        // Place the event in the cycle where the counter holds the lockup value.
        d = (rel_cyc + 65534 - 1 - longint'(DEB) - cyc) % 65536;
        if (d < 0) d += 65536;
        for (longint i = 0; i < d; i++) begin
            @(posedge clock);
            #1;
        end
        qual(10, 1'b0, 1, 1'b1, 1'b0);
        chk("lockup_data_in", 32'(wr_dat_q[wr_dat_q.size()-1]), 32'hFFFE);
        chk("lockup_seed_out", 32'(seed_out), 32'hFFFE);

        qual(8, 1'b0, 1, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            trigger = 1'b1;
            @(posedge clock);
            #1;
        end
        chk("wr_en_before_reset", 32'(bus.wr_en), 32'd1);
        nreset  = 1'b0;
        trigger = 1'b0;
        @(posedge clock);
        #1;
        chk("midrst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("midrst_seed_valid", 32'(seed_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_seed_out", 32'(seed_out), 32'd0);
        rel_cyc = cyc;
        nreset  = 1'b1;

        qual(10, 1'b0, 1, 1'b1, 1'b0);

`ifdef SEED_WRITER_READBACK_EN
        corrupt = 1'b1;
        qual(10, 1'b0, 1 + RETRIES, 1'b0, 1'b1);
        corrupt = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
